tdc_stream_packer: RTL and testbench

Parametrised successor to the single-channel TDC result FIFO/serialiser. It buffers results from `NUM_CH` TDC channels in per-channel FIFOs and arbitrates between them round-robin. Each result goes out as a channel-tagged byte packet over the serial TX handshake, with line and frame marker bytes inserted on request from the MEMS controller. It sits between the TDC control blocks and the UART transmitter. It returns per-write completion and line/frame-flushed pulses.

---
 rtl/tdc_stream_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/tdc_stream_packer.sv | 168 ++++++++++++++++
 tb/tb_tdc_stream_packer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_stream_pkg.sv
// Shared constants and FSM encoding for the multi-channel TDC stream packer.
package tdc_stream_pkg;

    localparam logic [3:0] HDR_NIB        = 4'hD;
    localparam logic [7:0] LINE_MARK_DEF  = 8'hF1;
    localparam logic [7:0] FRAME_MARK_DEF = 8'hF2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_HOLD,
        ST_MARK,
        ST_HOLDM
    } state_t;

    // Round-robin successor of channel ch among n channels.
    function automatic logic [3:0] next_ch(input logic [3:0] ch, input int n);
        return (int'(ch) >= n - 1) ? 4'd0 : ch + 4'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a write while full is taken if a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      count;
    logic             do_wr, do_rd;

    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);
    assign full  = count[AW];
    assign empty = (count == '0);
    assign dout  = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + PTR_ONE;
            if (do_rd) rptr <= rptr + PTR_ONE;
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= din;
    end

endmodule

// File: rtl/tdc_stream_packer.sv
// Per-channel TDC result FIFOs, round-robin arbiter and byte serialiser with
// line/frame marker insertion toward the UART transmitter.
module tdc_stream_packer
    import tdc_stream_pkg::*;
#(
    parameter int         NUM_CH     = 2,
    parameter int         DATA_W     = 48,
    parameter int         FIFO_AW    = 5,
    parameter logic [7:0] LINE_MARK  = LINE_MARK_DEF,
    parameter logic [7:0] FRAME_MARK = FRAME_MARK_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        wr_en,
    input  logic [NUM_CH*DATA_W-1:0] din,
    output logic [NUM_CH-1:0]        wr_done,
    output logic [NUM_CH-1:0]        full,
    output logic [NUM_CH-1:0]        overflow,
    input  logic                     ovf_clr,
    input  logic                     new_line,
    input  logic                     new_frame,
    output logic                     line_done,
    output logic                     frame_done,
    output logic [7:0]               tx_data,
    output logic                     new_tx_data,
    input  logic                     tx_busy,
    output logic                     all_empty
);

    localparam int NBYTES = DATA_W / 8;

    logic [NUM_CH-1:0]             empty, pop, wr_ok;
    logic [NUM_CH-1:0][DATA_W-1:0] dout;
    logic [DATA_W-1:0]             sel_data, sreg;
    logic [3:0]                    rr, ch, sel, idx;
    logic                          sel_vld, line_pend, frame_pend;
    state_t                        state;

    // A full channel still accepts a write when it is being popped this cycle.
    assign wr_ok     = wr_en & (~full | pop);
    assign all_empty = (&empty) && (state == ST_IDLE);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        sync_fifo #(
            .WIDTH (DATA_W),
            .AW    (FIFO_AW)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .wr    (wr_ok[k]),
            .rd    (pop[k]),
            .din   (din[k*DATA_W +: DATA_W]),
            .dout  (dout[k]),
            .full  (full[k]),
            .empty (empty[k])
        );
    end

    // Pick the non-empty channel closest to rr going upward with wrap.
    always_comb begin
        int best, d;
        best     = NUM_CH;
        d        = 0;
        sel      = rr;
        sel_vld  = 1'b0;
        sel_data = '0;
        pop      = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!empty[j]) begin
                d = j - int'(rr);
                if (d < 0) d = d + NUM_CH;
                if (d < best) begin
                    best    = d;
                    sel     = 4'(j);
                    sel_vld = 1'b1;
                end
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (sel == 4'(j)) sel_data = dout[j];
            pop[j] = (state == ST_IDLE) && sel_vld && (sel == 4'(j));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_done  <= '0;
            overflow <= '0;
        end else begin
            wr_done  <= wr_ok;
            overflow <= (ovf_clr ? '0 : overflow) | (wr_en & ~wr_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rr          <= '0;
            ch          <= '0;
            idx         <= '0;
            sreg        <= '0;
            tx_data     <= '0;
            new_tx_data <= 1'b0;
            line_done   <= 1'b0;
            frame_done  <= 1'b0;
            line_pend   <= 1'b0;
            frame_pend  <= 1'b0;
        end else begin
            new_tx_data <= 1'b0;
            line_done   <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_vld) begin
                        sreg  <= sel_data;
                        ch    <= sel;
                        idx   <= '0;
                        state <= ST_SEND;
                    end else if (line_pend || frame_pend) begin
                        state <= ST_MARK;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        new_tx_data <= 1'b1;
                        if (idx == '0) begin
                            tx_data <= {HDR_NIB, ch};
                        end else begin
                            tx_data <= sreg[DATA_W-1 -: 8];
                            sreg    <= sreg << 8;
                        end
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (idx == 4'(NBYTES)) begin
                        rr    <= next_ch(ch, NUM_CH);
                        state <= ST_IDLE;
                    end else begin
                        idx   <= idx + 4'd1;
                        state <= ST_SEND;
                    end
                end
                ST_MARK: begin
                    if (!tx_busy) begin
                        new_tx_data <= 1'b1;
                        state       <= ST_HOLDM;
                        if (line_pend) begin
                            tx_data   <= LINE_MARK;
                            line_done <= 1'b1;
                            line_pend <= 1'b0;
                        end else begin
                            tx_data    <= FRAME_MARK;
                            frame_done <= 1'b1;
                            frame_pend <= 1'b0;
                        end
                    end
                end
                ST_HOLDM: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
            // A fresh request outranks the clear of a marker just sent.
            if (new_line)  line_pend  <= 1'b1;
            if (new_frame) frame_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tdc_stream_packer.sv
// Directed bench for tdc_stream_packer with NUM_CH=2, DATA_W=48, FIFO_AW=5.
module tb_tdc_stream_packer;

    localparam int NUM_CH  = 2;
    localparam int DATA_W  = 48;
    localparam int FIFO_AW = 5;

    logic                     clk = 1'b0, rst_n = 1'b1;
    logic [NUM_CH-1:0]        wr_en = '0;
    logic [NUM_CH*DATA_W-1:0] din = '0;
    logic                     ovf_clr = 1'b0, new_line = 1'b0, new_frame = 1'b0, tx_busy = 1'b0;
    logic [NUM_CH-1:0]        wr_done, full, overflow;
    logic                     line_done, frame_done, new_tx_data, all_empty;
    logic [7:0]               tx_data;

    int checks = 0, errors = 0, cyc = 0, stray = 0, cnt = 0;

    typedef struct {
        logic [7:0] b;
        logic       ld;
        logic       fd;
        int         cyc;
    } ev_t;
    ev_t        q[$];
    logic [7:0] exp_q[$];

    tdc_stream_packer #(
        .NUM_CH (NUM_CH), .DATA_W (DATA_W), .FIFO_AW (FIFO_AW),
        .LINE_MARK (8'hF1), .FRAME_MARK (8'hF2)
    ) dut (
        .clk (clk), .rst_n (rst_n), .wr_en (wr_en), .din (din),
        .wr_done (wr_done), .full (full), .overflow (overflow), .ovf_clr (ovf_clr),
        .new_line (new_line), .new_frame (new_frame),
        .line_done (line_done), .frame_done (frame_done),
        .tx_data (tx_data), .new_tx_data (new_tx_data),
        .tx_busy (tx_busy), .all_empty (all_empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (new_tx_data) q.push_back('{tx_data, line_done, frame_done, cyc});
        if ((line_done || frame_done) && !new_tx_data) stray++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_pkt(input int c, input logic [47:0] d);
        exp_q.push_back({4'hD, 4'(c)});
        for (int i = 5; i >= 0; i--) exp_q.push_back(d[i*8 +: 8]);
    endtask

    task automatic wait_bytes(input int n, input string tag, input int settle);
        int t = 0;
        while (q.size() < n && t < 3000) begin
            step();
            t++;
        end
        repeat (settle) step();
        chk({tag, "_count"}, 64'(q.size()), 64'(n));
    endtask

    task automatic cmp_stream(input string tag);
        for (int i = 0; i < exp_q.size(); i++)
            if (i < q.size()) chk($sformatf("%s_byte%0d", tag, i), 64'(q[i].b), 64'(exp_q[i]));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        step();
        step();
        chk("rst_tx_data", 64'(tx_data), 64'h0);
        chk("rst_strobe", 64'(new_tx_data), 64'h0);
        chk("rst_wr_done", 64'(wr_done), 64'h0);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_overflow", 64'(overflow), 64'h0);
        chk("rst_marks", 64'({line_done, frame_done}), 64'h0);
        chk("rst_all_empty", 64'(all_empty), 64'h1);
        rst_n = 1'b1;
        step();

        // Single packet: latency and byte order.
        q.delete();
        exp_q.delete();
        wr_en = 2'b01;
        din[47:0] = 48'h0102_0304_0506;
        step();
        wr_en = '0;
        chk("t1_wr_done_c1", 64'(wr_done), 64'h1);
        chk("t1_not_empty_c1", 64'(all_empty), 64'h0);
        step();
        chk("t1_no_strobe_c2", 64'(new_tx_data), 64'h0);
        step();
        chk("t1_strobe_c3", 64'(new_tx_data), 64'h1);
        chk("t1_hdr_c3", 64'(tx_data), 64'hD0);
        push_pkt(0, 48'h0102_0304_0506);
        wait_bytes(7, "t1", 20);
        cmp_stream("t1");
        for (int i = 0; i < 6; i++) chk("t1_gap", 64'(q[i+1].cyc - q[i].cyc), 64'd2);
        chk("t1_idle_empty", 64'(all_empty), 64'h1);

        // Round robin between two channels.
        do_reset();
        wr_en = 2'b11;
        din = {48'h2122_2324_2526, 48'h1112_1314_1516};
        step();
        din = {48'h4142_4344_4546, 48'h3132_3334_3536};
        step();
        wr_en = '0;
        push_pkt(0, 48'h1112_1314_1516);
        push_pkt(1, 48'h2122_2324_2526);
        push_pkt(0, 48'h3132_3334_3536);
        push_pkt(1, 48'h4142_4344_4546);
        wait_bytes(28, "t2", 20);
        cmp_stream("t2");

        // Overflow, clear priority, write-on-pop while full.
        do_reset();
        tx_busy = 1'b1;
        wr_en = 2'b01;
        din[47:0] = 48'hC0C1_C2C3_C4C5;
        step();
        wr_en = '0;
        step();
        step();
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            wr_en = 2'b10;
            din[95:48] = 48'hA000_0000_0000 | 48'(i);
            step();
            if (wr_done[1]) cnt++;
        end
        chk("t3_fill_done_cnt", 64'(cnt), 64'd32);
        chk("t3_full", 64'(full), 64'h2);
        din[95:48] = 48'hBAD0_0000_0000;
        step();
        chk("t3_drop_no_done", 64'(wr_done), 64'h0);
        chk("t3_drop_ovf", 64'(overflow), 64'h2);
        ovf_clr = 1'b1;
        step();
        chk("t3_ovf_clr_vs_drop", 64'(overflow), 64'h2);
        wr_en = '0;
        step();
        chk("t3_ovf_cleared", 64'(overflow), 64'h0);
        ovf_clr = 1'b0;
        chk("t3_busy_no_strobe", 64'(q.size()), 64'd0);
        tx_busy = 1'b0;
        for (int i = 0; i < 14; i++) step();
        chk("t3_ch0_sent", 64'(q.size()), 64'd7);
        chk("t3_full_at_pop", 64'(full), 64'h2);
        wr_en = 2'b10;
        din[95:48] = 48'h5A5A_5A5A_5A5A;
        step();
        wr_en = '0;
        chk("t3_wr_on_pop_done", 64'(wr_done), 64'h2);
        chk("t3_wr_on_pop_ovf", 64'(overflow), 64'h0);
        push_pkt(0, 48'hC0C1_C2C3_C4C5);
        for (int i = 0; i < 32; i++) push_pkt(1, 48'hA000_0000_0000 | 48'(i));
        push_pkt(1, 48'h5A5A_5A5A_5A5A);
        wait_bytes(238, "t3", 20);
        cmp_stream("t3");

        // Line marker waits for queued data.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wr_en = 2'b01;
            din[47:0] = 48'h7000_0000_0000 | 48'(i);
            step();
        end
        wr_en = '0;
        new_line = 1'b1;
        step();
        new_line = 1'b0;
        for (int i = 0; i < 3; i++) push_pkt(0, 48'h7000_0000_0000 | 48'(i));
        exp_q.push_back(8'hF1);
        wait_bytes(22, "t4", 20);
        cmp_stream("t4");
        chk("t4_ld_on_mark", 64'(q[21].ld), 64'h1);
        chk("t4_fd_on_mark", 64'(q[21].fd), 64'h0);
        chk("t4_ld_on_data", 64'(q[20].ld), 64'h0);
        chk("t4_mark_gap", 64'(q[21].cyc - q[20].cyc), 64'd3);

        // Line and frame together, plus a merged repeat of the line request.
        do_reset();
        new_line = 1'b1;
        new_frame = 1'b1;
        step();
        new_frame = 1'b0;
        step();
        new_line = 1'b0;
        exp_q.push_back(8'hF1);
        exp_q.push_back(8'hF2);
        wait_bytes(2, "t5", 30);
        cmp_stream("t5");
        chk("t5_first_done", 64'({q[0].ld, q[0].fd}), 64'h2);
        chk("t5_second_done", 64'({q[1].ld, q[1].fd}), 64'h1);
        chk("t5_all_empty", 64'(all_empty), 64'h1);

        // Long tx_busy stall mid-packet.
        do_reset();
        wr_en = 2'b01;
        din[47:0] = 48'h8899_AABB_CCDD;
        step();
        wr_en = '0;
        wait_bytes(3, "t6_pre", 0);
        tx_busy = 1'b1;
        repeat (100) step();
        chk("t6_stalled", 64'(q.size()), 64'd3);
        tx_busy = 1'b0;
        push_pkt(0, 48'h8899_AABB_CCDD);
        wait_bytes(7, "t6", 20);
        cmp_stream("t6");

        // Asynchronous reset mid-packet.
        q.delete();
        exp_q.delete();
        wr_en = 2'b01;
        din[47:0] = 48'h1234_5678_9ABC;
        step();
        wr_en = 2'b01;
        din[47:0] = 48'h1111_2222_3333;
        step();
        wr_en = '0;
        wait_bytes(2, "t7_pre", 0);
        rst_n = 1'b0;
        #1;
        chk("t7_tx_data", 64'(tx_data), 64'h0);
        chk("t7_strobe", 64'(new_tx_data), 64'h0);
        chk("t7_wr_done", 64'(wr_done), 64'h0);
        chk("t7_full_ovf", 64'({full, overflow}), 64'h0);
        chk("t7_all_empty", 64'(all_empty), 64'h1);
        step();
        step();
        rst_n = 1'b1;
        repeat (30) step();
        chk("t7_no_strobe", 64'(q.size()), 64'd2);
        chk("t7_still_empty", 64'(all_empty), 64'h1);

        chk("stray_done_pulses", 64'(stray), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
